// File: rtl/ga_pkg.sv
// Shared constants and vsync resync state encoding for the gate-array interrupt generator.
package ga_pkg;

  localparam int DIV_DEFAULT         = 52;
  localparam int VSYNC_DELAY_DEFAULT = 2;
  localparam int HOLD_DEFAULT        = 96;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RESYNC = 2'd2
  } vs_state_e;

endpackage

// File: rtl/ga_edge_det.sv
// Two-flop history on a clk_i-synchronous level; pulses valid the cycle after the edge is sampled.
module ga_edge_det (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] hist_q;
  logic [1:0] hist_d;

  // hist_q = {older sample, newer sample}
  assign hist_d = {hist_q[0], sig_i};

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      hist_q <= 2'b00;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rise_o = (hist_q == 2'b01);
  assign fall_o = (hist_q == 2'b10);

endmodule

// File: rtl/ga_int_gen.sv
// Raster interrupt generator: HSYNC divider, VSYNC resync, INT hold/ack/clear.
// Define GA_PRI_EN to enable the programmable raster-line interrupt (pri_line_i).
module ga_int_gen
  import ga_pkg::*;
#(
  parameter int DIV         = DIV_DEFAULT,
  parameter int CNT_W       = 6,
  parameter int VSYNC_DELAY = VSYNC_DELAY_DEFAULT,
  parameter int HOLD_CYCLES = HOLD_DEFAULT,
  parameter int LINE_W      = 8
) (
  input  logic              clk_i,
  input  logic              nreset_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              intack_i,
  input  logic              clr_i,
  input  logic [LINE_W-1:0] pri_line_i,
  output logic              nint_o,
  output logic [CNT_W-1:0]  cntr_o,
  output logic [LINE_W-1:0] line_o
);

  localparam int                HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [2:0]        VS_N     = 3'(VSYNC_DELAY);

  logic hsync_fall, vsync_rise, ack_rise, clr_rise;
  logic unused_hs_rise, unused_vs_fall, unused_ack_fall, unused_clr_fall;

  ga_edge_det u_hs_edge (
    .clk_i(clk_i), .nreset_i(nreset_i), .sig_i(hsync_i),
    .rise_o(unused_hs_rise), .fall_o(hsync_fall)
  );
  ga_edge_det u_vs_edge (
    .clk_i(clk_i), .nreset_i(nreset_i), .sig_i(vsync_i),
    .rise_o(vsync_rise), .fall_o(unused_vs_fall)
  );
  ga_edge_det u_ack_edge (
    .clk_i(clk_i), .nreset_i(nreset_i), .sig_i(intack_i),
    .rise_o(ack_rise), .fall_o(unused_ack_fall)
  );
  ga_edge_det u_clr_edge (
    .clk_i(clk_i), .nreset_i(nreset_i), .sig_i(clr_i),
    .rise_o(clr_rise), .fall_o(unused_clr_fall)
  );

  vs_state_e           vs_q, vs_d;
  logic [2:0]          vs_n_q, vs_n_d;
  logic [CNT_W-1:0]    cntr_q, cntr_d;
  logic [LINE_W-1:0]   line_q, line_d, line_inc;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                req_q, req_d;
  logic                div_req, pri_active, pri_req;

  always_comb begin
    vs_d   = vs_q;
    vs_n_d = vs_n_q;
    case (vs_q)
      IDLE: begin
        if (vsync_rise) begin
          vs_d   = WAIT;
          vs_n_d = '0;
        end
      end
      WAIT: begin
        if (vsync_rise) begin
          vs_n_d = '0;
        end else if (hsync_fall) begin
          vs_n_d = vs_n_q + 3'd1;
          if (vs_n_q + 3'd1 == VS_N) vs_d = RESYNC;
        end
      end
      RESYNC: begin
        vs_d   = IDLE;
        vs_n_d = '0;
      end
      default: vs_d = IDLE;
    endcase
  end

  // Priority: clear, resync, hsync divide, ack mask of the late-half flag.
  always_comb begin
    cntr_d  = cntr_q;
    div_req = 1'b0;
    if (clr_rise) begin
      cntr_d = '0;
    end else if (vs_q == RESYNC) begin
      div_req = cntr_q[CNT_W-1];
      cntr_d  = '0;
    end else if (hsync_fall) begin
      if (cntr_q == DIV_LAST) begin
        cntr_d  = '0;
        div_req = 1'b1;
      end else begin
        cntr_d = cntr_q + 1'b1;
        if (ack_rise) cntr_d[CNT_W-1] = 1'b0;
      end
    end else if (ack_rise) begin
      cntr_d[CNT_W-1] = 1'b0;
    end
  end

  assign line_inc = line_q + 1'b1;

  always_comb begin
    line_d = line_q;
    if (vsync_rise) begin
      line_d = '0;
    end else if (hsync_fall && (line_q != '1)) begin
      line_d = line_inc;
    end
  end

`ifdef GA_PRI_EN
  // The line only increments once per value per frame, so the compare fires once per frame.
  assign pri_active = (pri_line_i != '0);
  assign pri_req    = pri_active && hsync_fall && !vsync_rise && !clr_rise &&
                      (line_q != '1) && (line_inc == pri_line_i);
`else
  logic unused_pri_line;
  assign unused_pri_line = ^pri_line_i;
  assign pri_active      = 1'b0;
  assign pri_req         = 1'b0;
`endif

  assign req_d = (div_req && !pri_active) || pri_req;

  // An ack arriving with a fresh request must not release nint for one cycle.
  always_comb begin
    hold_d = hold_q;
    if (clr_rise) begin
      hold_d = '0;
    end else if (req_q) begin
      hold_d = HOLD_W'(1);
    end else if (hold_q != '0) begin
      if ((ack_rise && !req_d) || (hold_q == HOLD_MAX)) begin
        hold_d = '0;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      vs_q   <= IDLE;
      vs_n_q <= '0;
      cntr_q <= '0;
      line_q <= '0;
      hold_q <= '0;
      req_q  <= 1'b0;
    end else begin
      vs_q   <= vs_d;
      vs_n_q <= vs_n_d;
      cntr_q <= cntr_d;
      line_q <= line_d;
      hold_q <= hold_d;
      req_q  <= req_d;
    end
  end

  assign nint_o = (hold_q == '0);
  assign cntr_o = cntr_q;
  assign line_o = line_q;

endmodule

// File: tb/tb_ga_int_gen.sv
// Directed bench for ga_int_gen: divider, hold, ack/clear, resync, line counter, PRI.
module tb_ga_int_gen;

  logic       clk_i = 1'b0;
  logic       nreset_i, hsync_i, vsync_i, intack_i, clr_i;
  logic [7:0] pri_line_i;
  logic       nint_o;
  logic [5:0] cntr_o;
  logic [7:0] line_o;

  int checks   = 0;
  int failures = 0;
  int lowcnt;
  int lows;

  ga_int_gen dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .intack_i(intack_i), .clr_i(clr_i), .pri_line_i(pri_line_i),
    .nint_o(nint_o), .cntr_o(cntr_o), .line_o(line_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One HSYNC falling edge; on return the divider has taken it.
  task automatic hs_fall();
    hsync_i = 1'b0;
    step();
    hsync_i = 1'b1;
    step();
  endtask

  task automatic hs_n(input int n);
    for (int k = 0; k < n; k++) hs_fall();
  endtask

  task automatic vs_rise();
    vsync_i = 1'b1;
    step();
    step();
    vsync_i = 1'b0;
  endtask

  task automatic ack_pulse();
    intack_i = 1'b1;
    step();
    step();
    intack_i = 1'b0;
    step();
  endtask

  task automatic count_low();
    lowcnt = 0;
    while (nint_o === 1'b0 && lowcnt < 300) begin
      lowcnt++;
      step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    nreset_i = 1'b0; hsync_i = 1'b1; vsync_i = 1'b0;
    intack_i = 1'b0; clr_i = 1'b0; pri_line_i = 8'd0;
    repeat (3) step();
    chk("rst_cntr", cntr_o, 0);
    chk("rst_line", line_o, 0);
    chk("rst_nint", nint_o, 1);
    nreset_i = 1'b1;
    step();
    step();

    // 52 falls: count 1..51 then wrap, INT three cycles after the last fall, held 96 cycles
    for (int i = 1; i <= 51; i++) begin
      hs_fall();
      chk("t1_cntr", cntr_o, i);
    end
    hs_fall();
    chk("t1_wrap", cntr_o, 0);
    chk("t1_nint_pre", nint_o, 1);
    step();
    chk("t1_latency", nint_o, 0);
    chk("t1_line", line_o, 52);
    count_low();
    chk("t1_hold_len", lowcnt, 96);

    // ack 10 cycles into the interrupt
    hs_n(52);
    step();
    chk("t2_int", nint_o, 0);
    repeat (9) step();
    intack_i = 1'b1;
    step();
    chk("t2_pre_ack", nint_o, 0);
    step();
    chk("t2_ack_release", nint_o, 1);
    chk("t2_cntr", cntr_o, 0);
    intack_i = 1'b0;
    step();

    // ack coincident with hsync fall at 35 -> 36 with bit 5 cleared
    hs_n(35);
    chk("t4_cntr35", cntr_o, 35);
    hsync_i = 1'b0;
    intack_i = 1'b1;
    step();
    hsync_i = 1'b1;
    step();
    chk("t4_mask_inc", cntr_o, 4);
    intack_i = 1'b0;
    step();
    hs_n(30);
    ack_pulse();
    chk("t4_mask_only", cntr_o, 2);

    // resync in the late half raises INT
    hs_n(38);
    chk("t3_cntr40", cntr_o, 40);
    vs_rise();
    chk("t3_vs_line", line_o, 0);
    hs_fall();
    hs_fall();
    step();
    chk("t3_resync_cntr", cntr_o, 0);
    step();
    chk("t3_resync_int", nint_o, 0);
    chk("t3_line", line_o, 2);
    ack_pulse();
    chk("t3_acked", nint_o, 1);

    // resync in the early half: no INT
    hs_n(20);
    chk("t3b_cntr20", cntr_o, 20);
    vs_rise();
    hs_fall();
    hs_fall();
    step();
    chk("t3b_resync_cntr", cntr_o, 0);
    step();
    step();
    chk("t3b_no_int", nint_o, 1);

    // clear while INT pending at cntr 30
    hs_n(52);
    step();
    chk("t5_int", nint_o, 0);
    hs_n(30);
    chk("t5_cntr30", cntr_o, 30);
    chk("t5_still_low", nint_o, 0);
    clr_i = 1'b1;
    step();
    step();
    chk("t5_clr_nint", nint_o, 1);
    chk("t5_clr_cntr", cntr_o, 0);
    clr_i = 1'b0;
    hs_n(51);
    step();
    step();
    chk("t5_no_early", nint_o, 1);
    chk("t5_cntr51", cntr_o, 51);
    hs_fall();
    step();
    chk("t5_next_int", nint_o, 0);

    // resync request while INT held, with ack in the request cycle: request wins, hold restarts
    hs_n(32);
    vs_rise();
    hs_fall();
    hs_fall();
    intack_i = 1'b1;
    step();
    chk("t6_resync_cntr", cntr_o, 0);
    step();
    chk("t6_req_wins", nint_o, 0);
    intack_i = 1'b0;
    count_low();
    chk("t6_hold_restart", lowcnt, 96);

    // line saturation and vsync priority over hsync
    chk("t7_line2", line_o, 2);
    hs_n(260);
    chk("t7_line_sat", line_o, 255);
    vsync_i = 1'b1;
    hsync_i = 1'b0;
    step();
    hsync_i = 1'b1;
    step();
    vsync_i = 1'b0;
    chk("t7_vs_wins", line_o, 0);
    hs_fall();
    chk("t7_line1", line_o, 1);

    // programmable raster line 100
    pri_line_i = 8'd100;
    clr_i = 1'b1;
    step();
    step();
    clr_i = 1'b0;
    step();
    chk("pri_clr_nint", nint_o, 1);
    vs_rise();
    lows = 0;
`ifdef GA_PRI_EN
    for (int k = 1; k <= 99; k++) begin
      hs_fall();
      if (nint_o === 1'b0) lows++;
    end
    chk("pri_no_wrap_int", lows, 0);
    chk("pri_div_runs", cntr_o, 45);
    hs_fall();
    step();
    chk("pri_int", nint_o, 0);
    chk("pri_line100", line_o, 100);
    ack_pulse();
    chk("pri_acked", nint_o, 1);
    for (int k = 1; k <= 100; k++) begin
      hs_fall();
      if (nint_o === 1'b0) lows++;
    end
    chk("pri_once_per_frame", lows, 0);
`else
    for (int k = 1; k <= 53; k++) begin
      hs_fall();
      if (nint_o === 1'b0) lows++;
    end
    chk("nopri_no_early", lows, 0);
    chk("nopri_cntr51", cntr_o, 51);
    hs_fall();
    step();
    chk("nopri_wrap_int", nint_o, 0);
    chk("nopri_line54", line_o, 54);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
